ch_mem_beam_seq: RTL



---
 rtl/ch_mem_pkg.sv | 22 ++
 rtl/ch_delay_table.sv | 36 +++
 rtl/ch_mem_beam_seq.sv | 111 +++++++++++
 3 files changed

// File: rtl/ch_mem_pkg.sv
// Shared sizing and FSM state type for the beam sequencer.
// Widths derive from the tap count and channel count defaults.
package ch_mem_pkg;

    localparam int N_TAPS = 20;
    localparam int N_CH   = 4;
    localparam int L      = 10;

    localparam int TW  = $clog2(N_TAPS);
    localparam int CW  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int TDW = L + 1;
    localparam int SW  = L + 1 + CW;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        SCAN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/ch_delay_table.sv
// Per-channel steering delay registers.
// Writes are clamped to the last tap and accepted only while idle.
module ch_delay_table
    import ch_mem_pkg::*;
(
    input  logic          clk_clk,
    input  logic          reset_n,
    input  logic          idle,
    input  logic          cfg_we,
    input  logic [CW-1:0] cfg_ch,
    input  logic [TW-1:0] cfg_delay,
    input  logic [CW-1:0] rd_idx,
    output logic [TW-1:0] rd_delay
);

    logic [TW-1:0] table_q [N_CH];
    logic [TW-1:0] wr_val;
    logic          wr_en;

    assign wr_en  = cfg_we && idle && (int'(cfg_ch) < N_CH);
    assign wr_val = (int'(cfg_delay) >= N_TAPS) ? TW'(N_TAPS - 1)
                                                : cfg_delay;

    always_ff @(posedge clk_clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CH; i++) begin
                table_q[i] <= '0;
            end
        end else if (wr_en) begin
            table_q[cfg_ch] <= wr_val;
        end
    end

    assign rd_delay = (int'(rd_idx) < N_CH) ? table_q[rd_idx] : '0;

endmodule

// File: rtl/ch_mem_beam_seq.sv
// Delay-and-sum sequencer: shifts every delay line once per sample,
// then reads one steered tap per channel and sums them into a beam sample.
module ch_mem_beam_seq
    import ch_mem_pkg::*;
(
    input  logic           clk_clk,
    input  logic           reset_n,
    input  logic           sample_valid,
    output logic           sample_ready,
    output logic           overrun,
    input  logic           cfg_we,
    input  logic [CW-1:0]  cfg_ch,
    input  logic [TW-1:0]  cfg_delay,
    output logic           cfg_busy,
    output logic           shift_en,
    output logic [CW-1:0]  rd_ch,
    output logic [TW-1:0]  rd_tap,
    output logic           rd_valid,
    input  logic [TDW-1:0] tap_data,
    output logic [SW-1:0]  beam_sum,
    output logic           beam_valid
);

    state_t        state;
    logic          tap_pend;
    logic [SW-1:0] acc;
    logic [SW-1:0] acc_next;
    logic [SW-1:0] tap_ext;
    logic [CW-1:0] next_ch;
    logic [TW-1:0] next_tap;

    assign sample_ready = (state == IDLE);
    assign cfg_busy     = (state != IDLE);

    // Table is read one cycle ahead so rd_tap can be registered with rd_ch.
    assign next_ch = (state == SCAN) ? rd_ch + CW'(1) : '0;

    ch_delay_table u_table (
        .clk_clk   (clk_clk),
        .reset_n   (reset_n),
        .idle      (sample_ready),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_delay (cfg_delay),
        .rd_idx    (next_ch),
        .rd_delay  (next_tap)
    );

    assign tap_ext  = {{CW{tap_data[TDW-1]}}, tap_data};
    assign acc_next = tap_pend ? acc + tap_ext : acc;

    always_ff @(posedge clk_clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            shift_en   <= 1'b0;
            rd_valid   <= 1'b0;
            rd_ch      <= '0;
            rd_tap     <= '0;
            tap_pend   <= 1'b0;
            acc        <= '0;
            beam_sum   <= '0;
            beam_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            shift_en   <= 1'b0;
            beam_valid <= 1'b0;
            tap_pend   <= rd_valid;
            acc        <= acc_next;
            if (sample_valid && !sample_ready) begin
                overrun <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (sample_valid) begin
                        state    <= SHIFT;
                        shift_en <= 1'b1;
                        acc      <= '0;
                    end
                end
                SHIFT: begin
                    state    <= SCAN;
                    rd_valid <= 1'b1;
                    rd_ch    <= '0;
                    rd_tap   <= next_tap;
                end
                SCAN: begin
                    if (rd_ch == CW'(N_CH - 1)) begin
                        state    <= DRAIN;
                        rd_valid <= 1'b0;
                    end else begin
                        rd_ch  <= next_ch;
                        rd_tap <= next_tap;
                    end
                end
                DRAIN: begin
                    // Last tap lands this cycle; fold it in directly.
                    state      <= DONE;
                    beam_sum   <= acc_next;
                    beam_valid <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
